spi_shift_engine: RTL and testbench
===================================

Name: spi_shift_engine

Overview:
Bit-level SPI master serialiser that sits directly downstream of the SPI register/FIFO wrapper. It consumes one byte per transmit request from the TX FIFO head and shifts it out on MOSI while shifting MISO in. It returns the received byte with a one-cycle acknowledge that pops the TX FIFO and pushes the RX FIFO. It supports all four CPOL/CPHA modes, MSB- or LSB-first order, and a programmable SCK divider.

Parameters:
cs_w, 8, width of chip-select vector

Ports:
clk  input  1  clock
rstn  input  1  reset, asynchronous, active-low
cs_v  input  cs_w  chip-select values from the register block
dfv  input  8  divider value; SCK half-period = dfv+1 clk cycles
tx_data  input  8  byte at the TX FIFO head
rx_data  output  8  last fully received byte
cpol  input  1  SCK idle level
cpha  input  1  0: sample on leading edge; 1: sample on trailing edge
msb_lsb  input  1  1: MSB first; 0: LSB first
tx_req  input  1  TX FIFO not empty
tx_req_ack  output  1  one-cycle pulse: byte done, pop TX, push RX
spi_mosi  output  1  serial data out
spi_miso  input  1  serial data in
spi_sck  output  1  serial clock
spi_cs  output  cs_w  chip selects

Behaviour:
- Clock and reset: one clock `clk`. Reset `rstn` is asynchronous and active-low.
- Reset values: spi_sck=0, spi_mosi=0, spi_cs='1, rx_data=0, tx_req_ack=0. State=IDLE, all counters=0.
- Reset mid-transfer: aborts immediately to the reset values. No ack is issued and rx_data is not updated.
- spi_cs: registered copy of cs_v, one cycle late, in every state. The engine never modifies it; software owns CS.
- FSM states: IDLE, SHIFT, ACK.
- IDLE:
  - spi_sck = cpol (registered), spi_mosi = 0.
  - If tx_req=1, latch tx_data, dfv, cpol, cpha and msb_lsb into shadow registers and go to SHIFT. Clear div_cnt and edge_cnt.
  - tx_req is sampled only in IDLE.
- SHIFT:
  - div_cnt counts 0..dfv_s. When div_cnt==dfv_s, it wraps to 0, spi_sck toggles, and edge_cnt increments (0..15).
  - Edges with even edge_cnt are leading edges; odd are trailing edges. There are 16 edges per byte.
  - cpha=0:
    - First bit is driven on MOSI on entry to SHIFT.
    - MISO is sampled on each leading edge.
    - The next bit is driven on each trailing edge, except the final one.
  - cpha=1:
    - MOSI drives the next bit on each leading edge.
    - MISO is sampled on each trailing edge.
  - Bit order: msb_lsb_s=1 shifts left (bit7 first, received bits enter at bit0). msb_lsb_s=0 shifts right (bit0 first, received bits enter at bit7).
  - After the 16th edge (edge_cnt==15 event), spi_sck is back at cpol_s. Go to ACK.
- ACK (exactly one cycle):
  - tx_req_ack=1, rx_data <= assembled byte, spi_mosi=0. Next state IDLE.
- Timing:
  - With tx_req seen in IDLE at cycle T, SHIFT occupies T+1..T+16*(dfv+1) and ACK is at T+16*(dfv+1)+1.
  - The first SCK edge occurs at T+1+dfv.
  - Minimum gap between bytes: one IDLE cycle after ACK, so the FIFO empty flag has updated before re-sampling.
- Configuration inputs (dfv, cpol, cpha, msb_lsb, tx_data) changing during SHIFT have no effect until the next IDLE capture.
- A cpol change in IDLE appears on spi_sck on the next cycle.
- dfv=0: SCK toggles every clk, giving SCK period = 2 clk. dfv=255: half-period = 256 clk. No overflow, since div_cnt is 8-bit and compares for equality.
- tx_req held high continuously gives back-to-back bytes separated by the ACK and IDLE cycles only.
- rx_data holds its value between acks.

Test Plan:
- Mode 0, MSB first, dfv=0, tx_data=0xA5, MISO driven from a shift register of 0x3C:
  - MOSI shows 1,0,1,0,0,1,0,1 on the rising edges.
  - 8 rising SCK edges occur.
  - tx_req_ack pulses at T+17.
  - rx_data=0x3C.
- Mode 3, LSB first, dfv=3, tx_data=0x81, slave returns 0x5A:
  - SCK idles high, half-period 4 clk.
  - MOSI order is 1,0,0,0,0,0,0,1.
  - Ack at T+65.
  - rx_data=0x5A.
- Modes 1 and 2 with dfv=1 and tx_data=0xF0, loopback MISO=MOSI -> rx_data=0xF0 in both modes, and sampling falls on the correct edge for each mode.
- tx_req held high for 3 bytes (0x11, 0x22, 0x33), dfv=0:
  - 3 ack pulses, each spaced 18 cycles apart.
  - rx_data sequence matches the loopback bytes.
  - Changing cpha mid-byte does not affect the current byte.
- Assert rstn low at edge 7 of a transfer:
  - SCK=0, MOSI=0, CS='1 immediately.
  - No ack is issued.
  - After release, with tx_req=1, a new full byte completes correctly.
- cs_v=0xFE written while idle -> spi_cs=0xFE one cycle later, unchanged through a full transfer.

Source files
------------

// File: rtl/spi_shift_engine_if.sv
// Signal bundle between the SPI register/FIFO wrapper (plus the pads) and
// the bit-level shift engine.
//
//   master modport : register block / pad side. Drives configuration, the
//                    TX FIFO head and the MISO pin; observes the engine.
//   slave  modport : the shift engine itself.
//
//   cs_v       chip-select values from the register block
//   dfv        SCK divider, half-period = dfv+1 clk cycles
//   tx_data    byte at the TX FIFO head
//   rx_data    last fully received byte
//   cpol       SCK idle level
//   cpha       0: sample on leading edge, 1: sample on trailing edge
//   msb_lsb    1: MSB first, 0: LSB first
//   tx_req     TX FIFO not empty
//   tx_req_ack one-cycle pulse: pop TX FIFO, push RX FIFO
//   spi_*      serial pins
interface spi_shift_engine_if #(
  parameter int cs_w = 8
);
  logic [cs_w-1:0] cs_v;
  logic [7:0]      dfv;
  logic [7:0]      tx_data;
  logic [7:0]      rx_data;
  logic            cpol;
  logic            cpha;
  logic            msb_lsb;
  logic            tx_req;
  logic            tx_req_ack;
  logic            spi_mosi;
  logic            spi_miso;
  logic            spi_sck;
  logic [cs_w-1:0] spi_cs;

  modport master (
    output cs_v, dfv, tx_data, cpol, cpha, msb_lsb, tx_req, spi_miso,
    input  rx_data, tx_req_ack, spi_mosi, spi_sck, spi_cs
  );

  modport slave (
    input  cs_v, dfv, tx_data, cpol, cpha, msb_lsb, tx_req, spi_miso,
    output rx_data, tx_req_ack, spi_mosi, spi_sck, spi_cs
  );
endinterface

// File: rtl/spi_shift_engine.sv
// Bit-level SPI master serialiser. Takes one byte from the TX FIFO head per
// request, shifts it out on MOSI while shifting MISO in, then pulses
// tx_req_ack for one cycle with the received byte on rx_data.
// Supports CPOL/CPHA modes 0..3, MSB/LSB first and a programmable divider.
//
// Ports:
//   clk   clock
//   rstn  asynchronous active-low reset
//   bus   spi_shift_engine_if.slave (configuration, FIFO handshake, pins)
module spi_shift_engine #(
  parameter int cs_w = 8
) (
  input  logic                clk,
  input  logic                rstn,
  spi_shift_engine_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, ACK} state_t;

  state_t      state;
  state_t      state_nxt;

  logic [7:0]  div_cnt;
  logic [3:0]  edge_cnt;
  logic [7:0]  tx_sh;
  logic [7:0]  rx_sh;
  logic [7:0]  rx_nxt;

  // Shadow copies captured in IDLE; the live inputs are ignored mid-byte.
  logic [7:0]  dfv_s;
  logic        cpol_s;
  logic        cpha_s;
  logic        msb_s;

  logic        sck_evt;
  logic        lead_evt;
  logic        trail_evt;
  logic        last_evt;
  logic        drive_evt;
  logic        samp_evt;

  function automatic logic head_bit(input logic [7:0] b, input logic msb_first);
    return msb_first ? b[7] : b[0];
  endfunction

  function automatic logic [7:0] shift_out(input logic [7:0] b, input logic msb_first);
    return msb_first ? {b[6:0], 1'b0} : {1'b0, b[7:1]};
  endfunction

  function automatic logic [7:0] shift_in(input logic [7:0] b, input logic msb_first,
                                          input logic bit_in);
    return msb_first ? {b[6:0], bit_in} : {bit_in, b[7:1]};
  endfunction

  // An SCK edge happens when the divider reaches the captured terminal
  // count; even edge numbers are leading edges, odd ones trailing.
  always_comb begin
    sck_evt   = (state == SHIFT) && (div_cnt == dfv_s);
    lead_evt  = sck_evt && !edge_cnt[0];
    trail_evt = sck_evt &&  edge_cnt[0];
    last_evt  = sck_evt && (edge_cnt == 4'd15);
    // CPHA=0 already presented bit 0 on entry, so it only advances on
    // trailing edges and must not shift past the final bit.
    drive_evt = cpha_s ? lead_evt : (trail_evt && !last_evt);
    samp_evt  = cpha_s ? trail_evt : lead_evt;
    rx_nxt    = samp_evt ? shift_in(rx_sh, msb_s, bus.spi_miso) : rx_sh;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.tx_req) state_nxt = SHIFT;
      SHIFT:   if (last_evt)   state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_cnt        <= '0;
      edge_cnt       <= '0;
      tx_sh          <= '0;
      rx_sh          <= '0;
      dfv_s          <= '0;
      cpol_s         <= 1'b0;
      cpha_s         <= 1'b0;
      msb_s          <= 1'b0;
      bus.spi_sck    <= 1'b0;
      bus.spi_mosi   <= 1'b0;
      bus.spi_cs     <= '1;
      bus.rx_data    <= '0;
      bus.tx_req_ack <= 1'b0;
    end else begin
      // Chip selects belong to software; the engine only retimes them.
      bus.spi_cs     <= bus.cs_v;
      bus.tx_req_ack <= last_evt;

      case (state)
        IDLE: begin
          bus.spi_sck  <= bus.cpol;
          bus.spi_mosi <= 1'b0;
          if (bus.tx_req) begin
            dfv_s    <= bus.dfv;
            cpol_s   <= bus.cpol;
            cpha_s   <= bus.cpha;
            msb_s    <= bus.msb_lsb;
            div_cnt  <= '0;
            edge_cnt <= '0;
            rx_sh    <= '0;
            if (bus.cpha) begin
              tx_sh <= bus.tx_data;
            end else begin
              bus.spi_mosi <= head_bit(bus.tx_data, bus.msb_lsb);
              tx_sh        <= shift_out(bus.tx_data, bus.msb_lsb);
            end
          end
        end

        SHIFT: begin
          rx_sh <= rx_nxt;
          if (sck_evt) begin
            div_cnt     <= '0;
            edge_cnt    <= edge_cnt + 4'd1;
            bus.spi_sck <= ~bus.spi_sck;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
          if (drive_evt) begin
            bus.spi_mosi <= head_bit(tx_sh, msb_s);
            tx_sh        <= shift_out(tx_sh, msb_s);
          end
          // Publish the byte (including a sample taken on this very edge)
          // so it is valid alongside the acknowledge pulse.
          if (last_evt) begin
            bus.spi_mosi <= 1'b0;
            bus.rx_data  <= rx_nxt;
          end
        end

        ACK: begin
          bus.spi_mosi <= 1'b0;
        end

        default: begin
          bus.spi_mosi <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_shift_engine.sv
// Directed bench for spi_shift_engine with a cycle-level reference model
// derived from the transfer timing rules and a simple SPI slave.
module tb_spi_shift_engine;
  localparam int CS_W = 8;
  localparam int PH_IDLE = 0, PH_SHIFT = 1, PH_ACK = 2;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  spi_shift_engine_if #(.cs_w(CS_W)) bus ();
  spi_shift_engine #(.cs_w(CS_W)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  int checks = 0;
  int errors = 0;

  // Slave side
  logic       loopback = 1'b0;
  logic [7:0] slave_byte = 8'h00;
  logic       slave_bit = 1'b0;
  assign bus.spi_miso = loopback ? bus.spi_mosi : slave_bit;

  // Reference model state (owned by the negedge process)
  int         ph = PH_IDLE;
  int         k = 0;
  int         d = 0;
  int         e = 0;
  logic       cpol_s = 1'b0, cpha_s = 1'b0, msb_s = 1'b0;
  logic [7:0] tx_s = 8'h00, exp_rx = 8'h00;
  logic       p_sck = 1'b0, p_mosi = 1'b0, p_ack = 1'b0;
  logic [7:0] p_rx = 8'h00;
  logic [CS_W-1:0] p_cs = '1;

  // Pin monitor
  logic       prev_sck = 1'b0, prev_mosi = 1'b0;
  int         sl_edges = 0;
  int         rise_cnt = 0;
  logic [7:0] mosi_seq = 8'h00;
  int         ack_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic order_bit(input logic [7:0] b, input logic msb, input int i);
    int j;
    j = (i > 7) ? 7 : i;
    return msb ? b[7-j] : b[j];
  endfunction

  // MOSI after e completed SCK edges: CPHA=0 presents bit i from the start
  // of pair i; CPHA=1 presents it from leading edge 2i onward.
  function automatic logic mosi_at(input int edges);
    if (!cpha_s)        return order_bit(tx_s, msb_s, edges / 2);
    else if (edges == 0) return 1'b0;
    else                return order_bit(tx_s, msb_s, (edges - 1) / 2);
  endfunction

  always @(negedge clk) begin
    // compare
    if (!rstn) begin
      check("rst_sck",  {31'd0, bus.spi_sck},  32'd0);
      check("rst_mosi", {31'd0, bus.spi_mosi}, 32'd0);
      check("rst_ack",  {31'd0, bus.tx_req_ack}, 32'd0);
      check("rst_cs",   {24'd0, bus.spi_cs},   32'hFF);
      check("rst_rx",   {24'd0, bus.rx_data},  32'd0);
    end else begin
      check("sck",  {31'd0, bus.spi_sck},    {31'd0, p_sck});
      check("mosi", {31'd0, bus.spi_mosi},   {31'd0, p_mosi});
      check("ack",  {31'd0, bus.tx_req_ack}, {31'd0, p_ack});
      check("cs",   {24'd0, bus.spi_cs},     {24'd0, p_cs});
      check("rx",   {24'd0, bus.rx_data},    {24'd0, p_rx});
    end

    // monitor
    if (rstn && bus.tx_req_ack === 1'b1) ack_total++;
    if (rstn && ph != PH_IDLE && bus.spi_sck !== prev_sck) begin
      sl_edges++;
      if (bus.spi_sck) begin
        rise_cnt++;
        mosi_seq = {mosi_seq[6:0], prev_mosi};
      end
    end
    prev_sck  = bus.spi_sck;
    prev_mosi = bus.spi_mosi;

    // advance model to the cycle after the next posedge
    if (!rstn) begin
      ph = PH_IDLE;
      p_sck = 1'b0; p_mosi = 1'b0; p_ack = 1'b0; p_rx = 8'h00; p_cs = '1;
    end else begin
      p_cs = bus.cs_v;
      case (ph)
        PH_IDLE: begin
          p_sck = bus.cpol; p_mosi = 1'b0; p_ack = 1'b0;
          if (bus.tx_req) begin
            d = int'(bus.dfv);
            cpol_s = bus.cpol; cpha_s = bus.cpha; msb_s = bus.msb_lsb;
            tx_s = bus.tx_data;
            exp_rx = loopback ? bus.tx_data : slave_byte;
            k = 0;
            ph = PH_SHIFT;
            p_mosi = mosi_at(0);
            sl_edges = 0; rise_cnt = 0; mosi_seq = 8'h00;
          end
        end
        PH_SHIFT: begin
          k++;
          if (k == 16 * (d + 1)) begin
            ph = PH_ACK;
            p_sck = cpol_s; p_mosi = 1'b0; p_ack = 1'b1; p_rx = exp_rx;
          end else begin
            e = k / (d + 1);
            p_sck = cpol_s ^ e[0];
            p_mosi = mosi_at(e);
          end
        end
        default: begin
          ph = PH_IDLE;
          p_sck = bus.cpol; p_mosi = 1'b0; p_ack = 1'b0;
        end
      endcase
    end

    // slave presents its next bit with the same edge discipline as the master
    if (!cpha_s) slave_bit = order_bit(slave_byte, msb_s, sl_edges / 2);
    else         slave_bit = order_bit(slave_byte, msb_s, (sl_edges == 0) ? 0 : (sl_edges - 1) / 2);
  end

  task automatic wait_ack(output int lat);
    logic got;
    got = 1'b0;
    lat = 0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clk);
      if (bus.tx_req_ack === 1'b1) got = 1'b1;
      else lat++;
    end
    if (!got) check("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic launch(input logic c_pol, input logic c_pha, input logic c_msb,
                        input logic [7:0] c_dfv, input logic [7:0] c_tx,
                        input logic [7:0] c_slave, input logic c_lb);
    @(posedge clk); #1;
    bus.cpol = c_pol; bus.cpha = c_pha; bus.msb_lsb = c_msb;
    bus.dfv = c_dfv; bus.tx_data = c_tx;
    slave_byte = c_slave; loopback = c_lb; bus.tx_req = 1'b0;
    @(posedge clk); #1;
    bus.tx_req = 1'b1;
    @(posedge clk); #1;
    bus.tx_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int ack0;
    bus.cs_v = '1; bus.dfv = 8'd0; bus.tx_data = 8'h00;
    bus.cpol = 1'b0; bus.cpha = 1'b0; bus.msb_lsb = 1'b1; bus.tx_req = 1'b0;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    #1;
    check("reset_sck",  {31'd0, bus.spi_sck},    32'd0);
    check("reset_mosi", {31'd0, bus.spi_mosi},   32'd0);
    check("reset_cs",   {24'd0, bus.spi_cs},     32'hFF);
    check("reset_rx",   {24'd0, bus.rx_data},    32'd0);
    check("reset_ack",  {31'd0, bus.tx_req_ack}, 32'd0);

    // Mode 0, MSB first, dfv=0
    launch(1'b0, 1'b0, 1'b1, 8'd0, 8'hA5, 8'h3C, 1'b0);
    wait_ack(lat);
    check("m0_ack_offset", lat + 1, 32'd17);
    @(posedge clk); #1;
    check("m0_rx", {24'd0, bus.rx_data}, 32'h3C);
    check("m0_rises", rise_cnt, 32'd8);
    check("m0_mosi_seq", {24'd0, mosi_seq}, 32'hA5);

    // Mode 3, LSB first, dfv=3
    launch(1'b1, 1'b1, 1'b0, 8'd3, 8'h81, 8'h5A, 1'b0);
    wait_ack(lat);
    check("m3_ack_offset", lat + 1, 32'd65);
    @(posedge clk); #1;
    check("m3_rx", {24'd0, bus.rx_data}, 32'h5A);
    check("m3_rises", rise_cnt, 32'd8);
    check("m3_mosi_seq", {24'd0, mosi_seq}, 32'h81);

    // Modes 1 and 2, loopback
    launch(1'b0, 1'b1, 1'b1, 8'd1, 8'hF0, 8'h00, 1'b1);
    wait_ack(lat);
    check("m1_ack_offset", lat + 1, 32'd33);
    @(posedge clk); #1;
    check("m1_rx", {24'd0, bus.rx_data}, 32'hF0);
    launch(1'b1, 1'b0, 1'b1, 8'd1, 8'hF0, 8'h00, 1'b1);
    wait_ack(lat);
    @(posedge clk); #1;
    check("m2_rx", {24'd0, bus.rx_data}, 32'hF0);

    // Back-to-back bytes, tx_req held high, cpha flipped mid second byte
    @(posedge clk); #1;
    bus.cpol = 1'b0; bus.cpha = 1'b0; bus.msb_lsb = 1'b1; bus.dfv = 8'd0;
    bus.tx_data = 8'h11; loopback = 1'b1;
    @(posedge clk); #1;
    bus.tx_req = 1'b1;
    wait_ack(lat);
    check("b2b_first_offset", lat, 32'd17);
    check("b2b_rx0", {24'd0, bus.rx_data}, 32'h11);
    @(posedge clk); #1;
    bus.tx_data = 8'h22;
    repeat (6) @(posedge clk);
    #1 bus.cpha = 1'b1;
    wait_ack(lat);
    check("b2b_spacing1", lat + 7, 32'd18);
    check("b2b_rx1", {24'd0, bus.rx_data}, 32'h22);
    @(posedge clk); #1;
    bus.tx_data = 8'h33;
    wait_ack(lat);
    check("b2b_spacing2", lat + 1, 32'd18);
    check("b2b_rx2", {24'd0, bus.rx_data}, 32'h33);
    @(posedge clk); #1;
    bus.tx_req = 1'b0;

    // Chip selects written while idle
    @(posedge clk); #1;
    bus.cs_v = 8'hFE;
    @(posedge clk); #1;
    check("cs_update", {24'd0, bus.spi_cs}, 32'hFE);
    launch(1'b0, 1'b0, 1'b1, 8'd0, 8'h3C, 8'h00, 1'b1);
    wait_ack(lat);
    @(posedge clk); #1;
    check("cs_hold", {24'd0, bus.spi_cs}, 32'hFE);
    check("cs_rx", {24'd0, bus.rx_data}, 32'h3C);

    // Reset at edge 7 of a transfer
    launch(1'b0, 1'b0, 1'b1, 8'd1, 8'hFF, 8'hFF, 1'b0);
    for (int i = 0; i < 100 && sl_edges < 7; i++) begin
      @(posedge clk); #1;
    end
    check("abort_reached_edge7", {31'd0, sl_edges >= 7}, 32'd1);
    ack0 = ack_total;
    rstn = 1'b0;
    #1;
    check("abort_sck",  {31'd0, bus.spi_sck},  32'd0);
    check("abort_mosi", {31'd0, bus.spi_mosi}, 32'd0);
    check("abort_cs",   {24'd0, bus.spi_cs},   32'hFF);
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("abort_no_ack", ack_total - ack0, 32'd0);
    check("abort_rx", {24'd0, bus.rx_data}, 32'h00);
    launch(1'b0, 1'b0, 1'b1, 8'd0, 8'h96, 8'hC3, 1'b0);
    wait_ack(lat);
    check("post_abort_offset", lat + 1, 32'd17);
    @(posedge clk); #1;
    check("post_abort_rx", {24'd0, bus.rx_data}, 32'hC3);
    check("post_abort_mosi_seq", {24'd0, mosi_seq}, 32'h96);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
